// File: rtl/intr_flag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : intr_flag_ctrl
//  Description : Interrupt sequencer for the C/Z flag registers. Synchronises
//                and edge-detects the IRQ lines, latches them as pending, and
//                at an instruction boundary shadows C/Z, clears the live
//                flags and pulses INTR. RETIE restores the flags and re-enables
//                interrupts. Index 0 is the highest-priority source.
//  Revision    : 1.0 - initial release
// ============================================================================
module intr_flag_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,   // must be >= 2
    parameter int VEC_W       = 2    // clog2(NUM_SRC), minimum 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               instr_done,
    input  logic               sei,
    input  logic               cli,
    input  logic               retie,
    input  logic               c_in,
    input  logic               z_in,
    output logic               intr,
    output logic [VEC_W-1:0]   vector,
    output logic               flg_clr,
    output logic               flg_restore,
    output logic               shad_c,
    output logic               shad_z,
    output logic               ie,
    output logic               in_isr,
    output logic [NUM_SRC-1:0] pend
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        ISR   = 2'd2,
        EXIT  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [NUM_SRC-1:0] sync_chain [SYNC_STAGES];
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] irq_rise;
    logic [NUM_SRC-1:0] sel_onehot;
    logic [VEC_W-1:0]   sel;
    logic               take;

    // Synchroniser chains plus the previous synchronised level for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_chain[s] <= '0;
            end
            irq_prev <= '0;
        end else begin
            sync_chain[0] <= irq;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_chain[s] <= sync_chain[s-1];
            end
            irq_prev <= sync_chain[SYNC_STAGES-1];
        end
    end

    // Only a 0->1 transition of the synchronised level requests service
    assign irq_rise = sync_chain[SYNC_STAGES-1] & ~irq_prev;

    // Isolate the lowest set pending bit (highest priority) as a one-hot mask
    assign sel_onehot = pend & (~pend + NUM_SRC'(1));

    // Binary index of the lowest set pending bit; scanning downward lets the
    // lowest index overwrite any higher one
    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel = VEC_W'(i);
            end
        end
    end

    // Service is taken only from IDLE, at a boundary, with something pending
    assign take = (state == IDLE) && ie && (|pend) && instr_done;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and Moore strobe decode
    always_comb begin
        state_nx    = state;
        intr        = 1'b0;
        flg_clr     = 1'b0;
        flg_restore = 1'b0;
        in_isr      = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nx = ENTER;
                end
            end
            ENTER: begin
                intr     = 1'b1;
                flg_clr  = 1'b1;
                in_isr   = 1'b1;
                state_nx = ISR;
            end
            ISR: begin
                in_isr = 1'b1;
                if (retie) begin
                    state_nx = EXIT;
                end
            end
            EXIT: begin
                flg_restore = 1'b1;
                state_nx    = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Pending bits, vector, flag shadows and global enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= '0;
            vector <= '0;
            shad_c <= 1'b0;
            shad_z <= 1'b0;
            ie     <= 1'b0;
        end else begin
            // A fresh edge on the source being cleared keeps it pending
            pend <= (pend & ~(take ? sel_onehot : '0)) | irq_rise;
            if (take) begin
                vector <= sel;
                shad_c <= c_in;
                shad_z <= z_in;
            end
            if (take) begin
                ie <= 1'b0;
            end else if (state == EXIT) begin
                ie <= 1'b1;
            end else if (state == IDLE) begin
                // SEI/CLI only act outside service; CLI has precedence
                if (cli) begin
                    ie <= 1'b0;
                end else if (sei) begin
                    ie <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
